// File: rtl/vram_pkg.sv
// Shared constants and types for the text-mode VRAM arbiter and its clear/scroll engine.
package vram_pkg;
    localparam int COLS = 80;
    localparam int ROWS = 25;
    localparam int SIZE = COLS * ROWS * 2;
    localparam int AW   = 12;

    localparam logic [1:0] CMD_CLEAR  = 2'b01;
    localparam logic [1:0] CMD_SCROLL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SRD,
        S_SWR,
        S_FILL,
        S_DONE
    } eng_state_e;
endpackage

// File: rtl/vram_engine.sv
// Clear / scroll-up engine. Requests one RAM access per cycle; advances only when granted.
module vram_engine #(
    parameter int COLS = vram_pkg::COLS,
    parameter int ROWS = vram_pkg::ROWS
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [1:0]           cmd_i,
    input  logic [15:0]          fill_i,
    input  logic                 gnt_i,
    input  logic [7:0]           rdata_i,
    output logic                 req_o,
    output logic                 we_o,
    output logic [11:0]          addr_o,
    output logic [7:0]           wdata_o,
    output logic                 busy_o,
    output logic                 done_o,
    output vram_pkg::eng_state_e state_o
);
    import vram_pkg::*;

    localparam int          SIZE     = COLS * ROWS * 2;
    localparam logic [11:0] LAST_P   = 12'(SIZE - 1);
    localparam logic [11:0] ROW_B    = 12'(2 * COLS);
    localparam logic [11:0] SCR_LAST = 12'(SIZE - 2 * COLS - 1);
    localparam logic [11:0] FILL_P   = 12'(SIZE - 2 * COLS);

    eng_state_e  state_q, state_d;
    logic [11:0] ptr_q, ptr_d;
    logic [7:0]  hold_q, hold_d;
    logic        rd_pend_q, rd_pend_d;
    logic [7:0]  fill_byte;

    assign fill_byte = ptr_q[0] ? fill_i[15:8] : fill_i[7:0];
    assign state_o   = state_q;
    assign busy_o    = (state_q != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        req_o     = 1'b0;
        we_o      = 1'b0;
        addr_o    = ptr_q;
        wdata_o   = fill_byte;
        done_o    = 1'b0;
        rd_pend_d = 1'b0;
        // Read data lands one cycle after the read grant, whether or not SWR wins that cycle.
        hold_d    = rd_pend_q ? rdata_i : hold_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && cmd_i == CMD_CLEAR) begin
                    state_d = S_CLR;
                    ptr_d   = '0;
                end else if (start_i && cmd_i == CMD_SCROLL) begin
                    state_d = S_SRD;
                    ptr_d   = '0;
                end
            end
            S_CLR, S_FILL: begin
                req_o = 1'b1;
                we_o  = 1'b1;
                if (gnt_i) begin
                    if (ptr_q == LAST_P) state_d = S_DONE;
                    else                 ptr_d   = ptr_q + 12'd1;
                end
            end
            S_SRD: begin
                req_o  = 1'b1;
                addr_o = ptr_q + ROW_B;
                if (gnt_i) begin
                    state_d   = S_SWR;
                    rd_pend_d = 1'b1;
                end
            end
            S_SWR: begin
                req_o   = 1'b1;
                we_o    = 1'b1;
                wdata_o = rd_pend_q ? rdata_i : hold_q;
                if (gnt_i) begin
                    if (ptr_q == SCR_LAST) begin
                        state_d = S_FILL;
                        ptr_d   = FILL_P;
                    end else begin
                        state_d = S_SRD;
                        ptr_d   = ptr_q + 12'd1;
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
                ptr_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video > CPU > engine, one access per cycle, combinational grant mux.
module vram_arbiter #(
    parameter int COLS = vram_pkg::COLS,
    parameter int ROWS = vram_pkg::ROWS
) (
    input  logic                 CLOCK,
    input  logic                 RESET_N,
    input  logic                 VID_REQ,
    input  logic [11:0]          VID_ADDR,
    output logic [7:0]           VID_DATA,
    input  logic                 CPU_REQ,
    input  logic                 CPU_WE,
    input  logic [11:0]          CPU_ADDR,
    input  logic [7:0]           CPU_WDATA,
    output logic                 CPU_ACK,
    output logic [7:0]           CPU_RDATA,
    input  logic                 ENG_START,
    input  logic [1:0]           ENG_CMD,
    input  logic [15:0]          ENG_FILL,
    output logic                 ENG_BUSY,
    output logic                 ENG_DONE,
    output logic [11:0]          RAM_ADDR,
    output logic                 RAM_WE,
    output logic [7:0]           RAM_WDATA,
    input  logic [7:0]           RAM_RDATA,
    output vram_pkg::eng_state_e ENG_STATE
);
    localparam int          SIZE   = COLS * ROWS * 2;
    localparam logic [11:0] SIZE_A = 12'(SIZE);

    logic        cpu_in_range, cpu_gnt, eng_req, eng_gnt, eng_we, ram_we_mux;
    logic [11:0] eng_addr;
    logic [7:0]  eng_wdata;
    logic        cpu_ack_q, cpu_ack_d, cpu_rd_q, cpu_rd_d, vid_q, vid_d;

    assign cpu_in_range = (CPU_ADDR < SIZE_A);
    // The ACK cycle never grants, so a held CPU_REQ becomes a fresh access afterwards.
    assign cpu_gnt      = CPU_REQ & ~VID_REQ & ~cpu_ack_q;
    assign eng_gnt      = eng_req & ~VID_REQ & ~cpu_gnt;

    always_comb begin
        RAM_ADDR   = VID_ADDR;
        RAM_WDATA  = 8'h00;
        ram_we_mux = 1'b0;
        if (VID_REQ) begin
            RAM_ADDR = VID_ADDR;
        end else if (cpu_gnt) begin
            RAM_ADDR   = CPU_ADDR;
            RAM_WDATA  = CPU_WDATA;
            ram_we_mux = CPU_WE & cpu_in_range;
        end else if (eng_gnt) begin
            RAM_ADDR   = eng_addr;
            RAM_WDATA  = eng_wdata;
            ram_we_mux = eng_we;
        end
    end

    assign RAM_WE    = ram_we_mux & RESET_N;
    assign vid_d     = VID_REQ;
    assign cpu_ack_d = cpu_gnt;
    assign cpu_rd_d  = cpu_gnt & ~CPU_WE & cpu_in_range;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            vid_q     <= 1'b0;
            cpu_ack_q <= 1'b0;
            cpu_rd_q  <= 1'b0;
        end else begin
            vid_q     <= vid_d;
            cpu_ack_q <= cpu_ack_d;
            cpu_rd_q  <= cpu_rd_d;
        end
    end

    // RAM output register supplies the data; the flags select who owns it this cycle.
    assign VID_DATA  = vid_q    ? RAM_RDATA : 8'h00;
    assign CPU_RDATA = cpu_rd_q ? RAM_RDATA : 8'h00;
    assign CPU_ACK   = cpu_ack_q;

    vram_engine #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) u_engine (
        .clk_i   (CLOCK),
        .rst_ni  (RESET_N),
        .start_i (ENG_START),
        .cmd_i   (ENG_CMD),
        .fill_i  (ENG_FILL),
        .gnt_i   (eng_gnt),
        .rdata_i (RAM_RDATA),
        .req_o   (eng_req),
        .we_o    (eng_we),
        .addr_o  (eng_addr),
        .wdata_o (eng_wdata),
        .busy_o  (ENG_BUSY),
        .done_o  (ENG_DONE),
        .state_o (ENG_STATE)
    );
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_vram_arbiter;
    import vram_pkg::*;

    logic        CLOCK = 1'b0;
    logic        RESET_N = 1'b1;
    logic        VID_REQ = 1'b0, CPU_REQ = 1'b0, CPU_WE = 1'b0, ENG_START = 1'b0;
    logic [11:0] VID_ADDR = '0, CPU_ADDR = '0;
    logic [7:0]  CPU_WDATA = '0;
    logic [1:0]  ENG_CMD = '0;
    logic [15:0] ENG_FILL = '0;
    logic [7:0]  VID_DATA, CPU_RDATA, RAM_WDATA, RAM_RDATA;
    logic        CPU_ACK, ENG_BUSY, ENG_DONE, RAM_WE;
    logic [11:0] RAM_ADDR;
    eng_state_e  ENG_STATE;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem [0:4095];
    logic [7:0]  exp_q [$];

    vram_arbiter dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .VID_REQ(VID_REQ), .VID_ADDR(VID_ADDR), .VID_DATA(VID_DATA),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA),
        .ENG_START(ENG_START), .ENG_CMD(ENG_CMD), .ENG_FILL(ENG_FILL),
        .ENG_BUSY(ENG_BUSY), .ENG_DONE(ENG_DONE),
        .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE), .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA),
        .ENG_STATE(ENG_STATE)
    );

    always #20 CLOCK = ~CLOCK;

    // Read-before-write synchronous RAM.
    always @(posedge CLOCK) begin
        RAM_RDATA <= mem[RAM_ADDR];
        if (RAM_WE) mem[RAM_ADDR] = RAM_WDATA;
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLOCK);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 12'd5; CPU_WDATA = 8'h99;
        #2 RESET_N = 1'b0;
        tick(); tick(); mid();
        checks++; if (RAM_WE !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b want 0", RAM_WE); end
        checks++; if (ENG_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", ENG_BUSY); end
        checks++; if (ENG_DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", ENG_DONE); end
        checks++; if (CPU_ACK !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", CPU_ACK); end
        checks++; if (CPU_RDATA !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", CPU_RDATA); end
        checks++; if (VID_DATA !== 8'h00) begin errors++; $display("FAIL reset_vid_data: got %h want 00", VID_DATA); end
        checks++; if (ENG_STATE !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", ENG_STATE, S_IDLE); end
        tick();
        CPU_REQ = 1'b0; CPU_WE = 1'b0;
        tick();
        RESET_N = 1'b1;
        tick();
        checks++; if (mem[5] !== 8'h00) begin errors++; $display("FAIL reset_no_write: got %h want 00", mem[5]); end
    endtask

    task automatic test_priority();
        mem[16] = 8'hB0; mem[17] = 8'hB1; mem[18] = 8'hB2; mem[12'h123] = 8'h00;
        VID_REQ = 1'b1; CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 12'h123; CPU_WDATA = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            VID_ADDR = 12'(16 + i);
            mid();
            checks++; if ({RAM_WE, RAM_ADDR} !== {1'b0, 12'(16 + i)}) begin
                errors++; $display("FAIL prio_vid_mux%0d: got we=%b addr=%h want we=0 addr=%h", i, RAM_WE, RAM_ADDR, 12'(16 + i)); end
            if (i > 0) begin
                checks++; if (VID_DATA !== 8'(8'hB0 + i - 1)) begin
                    errors++; $display("FAIL prio_vid_data%0d: got %h want %h", i, VID_DATA, 8'(8'hB0 + i - 1)); end
            end
            checks++; if (CPU_ACK !== 1'b0) begin errors++; $display("FAIL prio_no_ack%0d: got %b want 0", i, CPU_ACK); end
            tick();
        end
        VID_REQ = 1'b0;
        mid();
        checks++; if (VID_DATA !== 8'hB2) begin errors++; $display("FAIL prio_vid_data2: got %h want b2", VID_DATA); end
        checks++; if ({RAM_WE, RAM_ADDR, RAM_WDATA} !== {1'b1, 12'h123, 8'hA5}) begin
            errors++; $display("FAIL prio_cpu_grant: got we=%b addr=%h wd=%h want 1/123/a5", RAM_WE, RAM_ADDR, RAM_WDATA); end
        checks++; if (CPU_ACK !== 1'b0) begin errors++; $display("FAIL prio_ack_early: got %b want 0", CPU_ACK); end
        tick(); mid();
        checks++; if (CPU_ACK !== 1'b1) begin errors++; $display("FAIL prio_ack: got %b want 1", CPU_ACK); end
        checks++; if (RAM_WE !== 1'b0) begin errors++; $display("FAIL prio_no_grant_in_ack: got we=%b want 0", RAM_WE); end
        tick();
        CPU_REQ = 1'b0; CPU_WE = 1'b0;
        mid();
        checks++; if (CPU_ACK !== 1'b0) begin errors++; $display("FAIL prio_ack_pulse: got %b want 0", CPU_ACK); end
        checks++; if (mem[12'h123] !== 8'hA5) begin errors++; $display("FAIL prio_ram_value: got %h want a5", mem[12'h123]); end
        tick();
    endtask

    task automatic test_cpu_read();
        mem[16] = 8'h41;
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 12'h010;
        mid();
        checks++; if ({RAM_WE, RAM_ADDR} !== {1'b0, 12'h010}) begin
            errors++; $display("FAIL rd_grant: got we=%b addr=%h want 0/010", RAM_WE, RAM_ADDR); end
        tick(); mid();
        checks++; if (CPU_ACK !== 1'b1) begin errors++; $display("FAIL rd_ack: got %b want 1", CPU_ACK); end
        checks++; if (CPU_RDATA !== 8'h41) begin errors++; $display("FAIL rd_data: got %h want 41", CPU_RDATA); end
        tick(); mid();
        checks++; if (CPU_ACK !== 1'b0) begin errors++; $display("FAIL rd_ack_gap: got %b want 0", CPU_ACK); end
        tick(); mid();
        checks++; if ({CPU_ACK, CPU_RDATA} !== {1'b1, 8'h41}) begin
            errors++; $display("FAIL rd_second: got ack=%b data=%h want 1/41", CPU_ACK, CPU_RDATA); end
        tick();
        CPU_REQ = 1'b0;
        mid();
        checks++; if ({CPU_ACK, CPU_RDATA} !== {1'b0, 8'h00}) begin
            errors++; $display("FAIL rd_idle: got ack=%b data=%h want 0/00", CPU_ACK, CPU_RDATA); end
        tick();
    endtask

    task automatic test_out_of_range();
        mem[4000] = 8'h33;
        CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 12'd4000; CPU_WDATA = 8'h5A;
        mid();
        checks++; if (RAM_WE !== 1'b0) begin errors++; $display("FAIL oor_we: got %b want 0", RAM_WE); end
        tick(); mid();
        checks++; if (CPU_ACK !== 1'b1) begin errors++; $display("FAIL oor_wr_ack: got %b want 1", CPU_ACK); end
        tick();
        CPU_REQ = 1'b0; CPU_WE = 1'b0;
        mid();
        checks++; if (mem[4000] !== 8'h33) begin errors++; $display("FAIL oor_mem: got %h want 33", mem[4000]); end
        tick();
        CPU_REQ = 1'b1;
        tick(); mid();
        checks++; if ({CPU_ACK, CPU_RDATA} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL oor_rd: got ack=%b data=%h want 1/00", CPU_ACK, CPU_RDATA); end
        tick();
        CPU_REQ = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        int n, done_at, writes, bad;
        logic busy1;
        for (int i = 0; i < 4000; i++) mem[i] = 8'hCC;
        ENG_FILL = 16'h1F20; ENG_CMD = CMD_CLEAR; ENG_START = 1'b1;
        tick();
        ENG_START = 1'b0; ENG_CMD = 2'b00;
        n = 1; done_at = 0; writes = 0; busy1 = 1'b0;
        while (done_at == 0 && n < 6000) begin
            mid();
            if (n == 1) busy1 = ENG_BUSY;
            if (RAM_WE) writes++;
            if (ENG_DONE) done_at = n;
            tick();
            n++;
        end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL clr_busy: got %b want 1", busy1); end
        checks++; if (done_at != 4001) begin errors++; $display("FAIL clr_done_cycle: got %0d want 4001", done_at); end
        checks++; if (writes != 4000) begin errors++; $display("FAIL clr_writes: got %0d want 4000", writes); end
        mid();
        checks++; if ({ENG_BUSY, ENG_DONE} !== 2'b00) begin
            errors++; $display("FAIL clr_idle: got busy=%b done=%b want 0/0", ENG_BUSY, ENG_DONE); end
        bad = 0;
        for (int i = 0; i < 4000; i++) if (mem[i] !== ((i % 2 == 0) ? 8'h20 : 8'h1F)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL clr_contents: got %0d bad bytes want 0", bad); end
        tick();
    endtask

    task automatic test_scroll();
        int n, done_at, dones, bad;
        logic vid_prev;
        logic [7:0] want, exp_b;
        for (int i = 0; i < 4000; i++) mem[i] = 8'(i / 160);
        ENG_FILL = 16'h0720; ENG_CMD = CMD_SCROLL; ENG_START = 1'b1;
        tick();
        ENG_START = 1'b0; ENG_CMD = 2'b00;
        n = 1; done_at = 0; dones = 0; vid_prev = 1'b0;
        while (n < 20000 && !(dones > 0 && n > done_at + 3)) begin
            VID_REQ   = (n % 8 < 2);
            VID_ADDR  = 12'($urandom_range(3999, 0));
            ENG_START = (n == 40);
            ENG_CMD   = (n == 40) ? CMD_CLEAR : 2'b00;
            mid();
            if (vid_prev) begin
                exp_b = exp_q.pop_front();
                checks++; if (VID_DATA !== exp_b) begin
                    errors++; $display("FAIL scr_vid_data@%0d: got %h want %h", n, VID_DATA, exp_b); end
            end
            if (VID_REQ) begin
                checks++; if ({RAM_WE, RAM_ADDR} !== {1'b0, VID_ADDR}) begin
                    errors++; $display("FAIL scr_vid_mux@%0d: got we=%b addr=%h want 0/%h", n, RAM_WE, RAM_ADDR, VID_ADDR); end
                exp_q.push_back(mem[VID_ADDR]);
            end
            vid_prev = VID_REQ;
            if (ENG_DONE) begin dones++; done_at = n; end
            tick();
            n++;
        end
        VID_REQ = 1'b0; ENG_START = 1'b0;
        mid();
        if (vid_prev) begin
            exp_b = exp_q.pop_front();
            checks++; if (VID_DATA !== exp_b) begin
                errors++; $display("FAIL scr_vid_last: got %h want %h", VID_DATA, exp_b); end
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL scr_done_count: got %0d want 1", dones); end
        bad = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i < 3840) want = 8'(i / 160 + 1);
            else          want = (i % 2 == 0) ? 8'h20 : 8'h07;
            if (mem[i] !== want) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL scr_contents: got %0d bad bytes want 0", bad); end
        tick();
    endtask

    task automatic test_reset_abort();
        int dones, bad;
        logic [7:0] want;
        for (int i = 0; i < 4000; i++) mem[i] = 8'hEE;
        ENG_FILL = 16'h1F20; ENG_CMD = CMD_CLEAR; ENG_START = 1'b1;
        tick();
        ENG_START = 1'b0; ENG_CMD = 2'b00;
        for (int i = 0; i < 100; i++) tick();
        mid();
        checks++; if ({RAM_WE, RAM_ADDR} !== {1'b1, 12'd100}) begin
            errors++; $display("FAIL abort_ptr: got we=%b addr=%0d want 1/100", RAM_WE, RAM_ADDR); end
        RESET_N = 1'b0;
        #1;
        checks++; if ({ENG_BUSY, RAM_WE} !== 2'b00) begin
            errors++; $display("FAIL abort_async: got busy=%b we=%b want 0/0", ENG_BUSY, RAM_WE); end
        tick(); tick();
        RESET_N = 1'b1;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            mid();
            if (ENG_DONE) dones++;
            tick();
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
        bad = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i < 100) want = (i % 2 == 0) ? 8'h20 : 8'h1F;
            else         want = 8'hEE;
            if (mem[i] !== want) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL abort_contents: got %0d bad bytes want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_cpu_read();
        test_out_of_range();
        test_clear();
        test_scroll();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameters: COLS default 80, text columns; ROWS default 25, text rows; SIZE = COLS*ROWS*2 = 4000, buffer bytes (char at even address, attribute at odd address).
REQ-002 CLOCK  in  1  sole clock, 25 MHz pixel clock; all logic SHALL use rising edge.
REQ-003 RESET_N  in  1  asynchronous, active-low reset.
REQ-004 VID_REQ  in  1  video fetch request, one byte per asserted cycle.
REQ-005 VID_ADDR  in  12  video fetch byte address.
REQ-006 VID_DATA  out  8  video read data, valid the cycle after VID_REQ.
REQ-007 CPU_REQ  in  1  CPU access request, held until CPU_ACK.
REQ-008 CPU_WE  in  1  1 = write, 0 = read.
REQ-009 CPU_ADDR  in  12  / CPU_WDATA  in  8  CPU address and write data, stable while CPU_REQ is high.
REQ-010 CPU_ACK  out  1  one-cycle completion pulse.
REQ-011 CPU_RDATA  out  8  read data, valid in the CPU_ACK cycle.
REQ-012 ENG_START  in  1  one-cycle command strobe.
REQ-013 ENG_CMD  in  2  01 clear, 10 scroll-up one row, 00/11 no-op.
REQ-014 ENG_FILL  in  16  {attr, char} fill word.
REQ-015 ENG_BUSY  out  1  engine active.
REQ-016 ENG_DONE  out  1  one-cycle completion pulse.
REQ-017 RAM_ADDR  out  12, RAM_WE  out  1, RAM_WDATA  out  8, RAM_RDATA  in  8: single-port synchronous RAM with 1-cycle read latency.

Function
REQ-018 Fixed priority per cycle: video > CPU > engine; at most one RAM access per cycle; the grant and RAM_ADDR/RAM_WE/RAM_WDATA mux SHALL be combinational in the request cycle.
REQ-019 Video: VID_REQ high SHALL always win; RAM_WE=0, RAM_ADDR=VID_ADDR; VID_DATA = RAM_RDATA in the next cycle. Video SHALL never stall.
REQ-020 CPU: granted in any cycle with CPU_REQ=1, VID_REQ=0, CPU_ACK=0; CPU_ACK SHALL pulse the cycle after the grant, with CPU_RDATA registered from RAM_RDATA for reads. No grant in the ACK cycle; if CPU_REQ stays high past ACK, it is a new access.
REQ-021 CPU_ADDR >= SIZE: the access SHALL still ACK, write suppressed (RAM_WE=0), read data 8'h00.
REQ-022 Engine FSM states: IDLE, CLR, SRD, SWR, FILL, DONE.
REQ-023 IDLE: ENG_START with CMD 01 -> CLR at pointer 0; CMD 10 -> SRD at pointer 0; other CMD values ignored. ENG_START while busy SHALL be ignored.
REQ-024 CLR: in each free cycle, write byte p (ENG_FILL[7:0] if p even, [15:8] if odd), then p+1; after p = SIZE-1 -> DONE.
REQ-025 SRD: in a free cycle, read p+2*COLS -> SWR. The cycle after the read grant, RAM_RDATA SHALL be captured into a hold register regardless of next-cycle grant.
REQ-026 SWR: in a free cycle, write the hold register to p, then p+1; if p = SIZE-2*COLS-1 -> FILL at p = SIZE-2*COLS, else -> SRD.
REQ-027 FILL: as CLR, over SIZE-2*COLS..SIZE-1, then -> DONE.
REQ-028 DONE: ENG_DONE=1 for one cycle -> IDLE. ENG_BUSY=1 in every state except IDLE.
REQ-029 Engine pointer SHALL be 12 bits and never exceed SIZE-1; a stalled engine state SHALL hold all of its registers.

Reset
REQ-030 On RESET_N=0, asynchronously: FSM=IDLE, pointer=0, hold=0, CPU_ACK=0, CPU_RDATA=0, VID_DATA=0, ENG_BUSY=0, ENG_DONE=0. RAM_WE SHALL be 0 while in reset.
REQ-031 Reset during an engine command SHALL abort it; the buffer is left partially updated and no ENG_DONE is issued.

Structure
REQ-032 Shared package vram_pkg: COLS, ROWS, SIZE, ENG_CMD encodings, FSM state enum.
REQ-033 One sub-module, vram_engine (clear/scroll FSM with its own request/grant), instantiated inside vram_arbiter; grant mux in the top.

Verification
REQ-034 VID_REQ and CPU_REQ write both high for 3 cycles -> 3 video reads; CPU write granted on cycle 4; CPU_ACK on cycle 5; RAM holds the value.
REQ-035 CPU read of 0x010 holding 0x41 with no video -> CPU_ACK and CPU_RDATA=0x41 one cycle after the grant; no grant in the ACK cycle.
REQ-036 Clear with ENG_FILL=16'h1F20 and no contention -> 4000 writes; even bytes=0x20, odd bytes=0x1F; ENG_DONE exactly 4001 cycles after ENG_START.
REQ-037 Scroll with row r filled by value r, fill 16'h0720, video active 2 of every 8 cycles -> row r holds r+1 for r<24; row 24 = 20/07 pairs; video data never corrupted.
REQ-038 ENG_START during scroll -> ignored; CPU_ADDR=4000 write -> ACK with no RAM write.
REQ-039 RESET_N low mid-clear at pointer 100 -> ENG_BUSY=0 immediately; no ENG_DONE; bytes 100+ unchanged.
